main_cu: RTL and testbench

- Multi-cycle main control unit for the 16-bit RISC core.
- Accepts each fetched instruction's 4-bit opcode and sequences the FETCH / DECODE / EXEC / MEM / WB steps.
- Produces the 2-bit ALU operation class (alu_op) consumed by the ALU control decoder, plus the register-file, data-memory and PC control strobes.
- Sits between the instruction fetch stage and the datapath.

---
 rtl/main_cu_pkg.sv | 51 +++++
 rtl/main_cu_opclass.sv | 29 ++
 rtl/main_cu.sv | 142 ++++++++++++++
 tb/tb_main_cu.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/main_cu_pkg.sv
// -----------------------------------------------------------------------------
// main_cu_pkg
//   Shared RISC definitions for the main control unit and the ALU control
//   decoder: opcode map, alu_op class encodings, pc_src encodings, main FSM
//   state encodings and the opcode-class flag record.
// -----------------------------------------------------------------------------
package main_cu_pkg;

  localparam int OP_W     = 4;
  localparam int ALU_OP_W = 2;

  // Opcode map. 0010..1001 are R-type ALU operations.
  localparam logic [OP_W-1:0] OP_LD   = 4'b0000;
  localparam logic [OP_W-1:0] OP_ST   = 4'b0001;
  localparam logic [OP_W-1:0] OP_R_LO = 4'b0010;
  localparam logic [OP_W-1:0] OP_R_HI = 4'b1001;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'b1011;
  localparam logic [OP_W-1:0] OP_BNE  = 4'b1100;
  localparam logic [OP_W-1:0] OP_JMP  = 4'b1101;

  // alu_op classes consumed by the ALU control decoder.
  localparam logic [ALU_OP_W-1:0] ALU_OP_MEM = 2'b10;
  localparam logic [ALU_OP_W-1:0] ALU_OP_BR  = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_OP_R   = 2'b00;

  // PC source select.
  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  // Main FSM state encodings.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  // One-hot instruction class of the latched opcode.
  typedef struct packed {
    logic is_r;
    logic is_ld;
    logic is_st;
    logic is_beq;
    logic is_bne;
    logic is_jmp;
    logic is_illegal;
  } op_class_t;

endpackage

// File: rtl/main_cu_opclass.sv
// -----------------------------------------------------------------------------
// main_cu_opclass
//   Combinational opcode classifier for the main control unit.
//   op  : latched instruction opcode
//   cls : class flags {is_r, is_ld, is_st, is_beq, is_bne, is_jmp, is_illegal}
// -----------------------------------------------------------------------------
module main_cu_opclass
  import main_cu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output op_class_t       cls
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    cls        = '0;
    cls.is_r   = (op >= OP_R_LO) && (op <= OP_R_HI);
    cls.is_ld  = (op == OP_LD);
    cls.is_st  = (op == OP_ST);
    cls.is_beq = (op == OP_BEQ);
    cls.is_bne = (op == OP_BNE);
    cls.is_jmp = (op == OP_JMP);
    // Holes in the map: 1010, 1110, 1111.
    cls.is_illegal = !(cls.is_r || cls.is_ld || cls.is_st ||
                       cls.is_beq || cls.is_bne || cls.is_jmp);
  end

endmodule

// File: rtl/main_cu.sv
// -----------------------------------------------------------------------------
// main_cu
//   Multi-cycle main control unit: sequences IDLE/FETCH/DECODE/EXEC/MEM/WB and
//   latches into TRAP on an illegal opcode.
//   clk, rst            : clock, asynchronous active-high reset
//   instr_valid/ready   : fetch handshake; accept = FETCH && instr_valid
//   opcode              : instruction opcode, sampled on accept
//   zero_flag           : ALU zero, used combinationally in EXEC (branches)
//   dmem_ack            : data memory completion, used only in MEM
//   alu_op, alu_src     : ALU operation class and B-operand select
//   reg_write, mem_to_reg : register file write strobe and source select
//   dmem_req, dmem_we   : data memory request (level) and store qualifier
//   ir_write, pc_write, pc_src : IR load, PC update strobe and source
//   illegal             : sticky illegal-opcode flag (TRAP state)
// -----------------------------------------------------------------------------
module main_cu
  import main_cu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OP_W-1:0]     opcode,
  input  logic                zero_flag,
  input  logic                dmem_ack,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                illegal
);

  logic [2:0]      state_q, state_d;
  logic [OP_W-1:0] op_q;
  op_class_t       cls;
  logic            accept;

  assign accept = (state_q == S_FETCH) && instr_valid;

  main_cu_opclass u_opclass (
    .op  (op_q),
    .cls (cls)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_LD;
    end else begin
      state_q <= state_d;
      if (accept) op_q <= opcode;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    alu_op      = ALU_OP_R;
    alu_src     = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_SEQ;
    illegal     = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SRC_SEQ;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        if (cls.is_jmp) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JMP;
          state_d  = S_FETCH;
        end else if (cls.is_illegal) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (cls.is_ld || cls.is_st) begin
          alu_op  = ALU_OP_MEM;
          alu_src = 1'b1;
          state_d = S_MEM;
        end else if (cls.is_beq || cls.is_bne) begin
          alu_op   = ALU_OP_BR;
          pc_src   = PC_SRC_BR;
          // BNE takes the branch on a non-zero compare.
          pc_write = cls.is_beq ? zero_flag : ~zero_flag;
          state_d  = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        alu_op   = ALU_OP_MEM;
        alu_src  = 1'b1;
        dmem_req = 1'b1;
        dmem_we  = cls.is_st;
        if (dmem_ack) state_d = cls.is_ld ? S_WB : S_FETCH;
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = cls.is_ld;
        // Keep the EXEC operand class stable for the whole instruction.
        if (cls.is_ld) begin
          alu_op  = ALU_OP_MEM;
          alu_src = 1'b1;
        end
        state_d = S_FETCH;
      end

      S_TRAP: illegal = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_main_cu.sv
// -----------------------------------------------------------------------------
// tb_main_cu
//   Directed, table-driven bench for main_cu plus hand-written sequences for
//   mid-MEM reset and per-class accept-to-accept latency.
// -----------------------------------------------------------------------------
module tb_main_cu;
  import main_cu_pkg::*;

  // {instr_ready, alu_op, alu_src, reg_write, mem_to_reg, dmem_req, dmem_we,
  //  ir_write, pc_write, pc_src, illegal}
  typedef struct packed {
    logic       ready;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       illegal;
  } out_t;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [3:0] op;
    logic       zf;
    logic       ack;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] opcode;
  logic       zero_flag;
  logic       dmem_ack;
  logic [1:0] alu_op;
  logic       alu_src, reg_write, mem_to_reg, dmem_req, dmem_we;
  logic       ir_write, pc_write, illegal;
  logic [1:0] pc_src;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  main_cu dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .zero_flag   (zero_flag),
    .dmem_ack    (dmem_ack),
    .alu_op      (alu_op),
    .alu_src     (alu_src),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .illegal     (illegal)
  );

  function automatic out_t o(input logic rdy, input logic [1:0] aop,
                             input logic src, input logic rw, input logic m2r,
                             input logic req, input logic we, input logic irw,
                             input logic pcw, input logic [1:0] pcs,
                             input logic ill);
    out_t r;
    r = '{rdy, aop, src, rw, m2r, req, we, irw, pcw, pcs, ill};
    return r;
  endfunction

  function automatic out_t actual();
    out_t r;
    r = '{instr_ready, alu_op, alu_src, reg_write, mem_to_reg, dmem_req,
          dmem_we, ir_write, pc_write, pc_src, illegal};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic iv, input logic [3:0] op,
                     input logic zf, input logic ack, input out_t e);
    vec_t v;
    v.rst = r; v.iv = iv; v.op = op; v.zf = zf; v.ack = ack; v.exp = e;
    vecs.push_back(v);
  endtask

  // Present one instruction and count rising edges from the accept edge until
  // instr_ready is seen again; bounded so a stuck FSM still ends the run.
  task automatic latency(input string name, input logic [3:0] op,
                         input int exp_cycles);
    int n;
    n = 0;
    while (!instr_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_ready_before"}, 32'(instr_ready), 32'd1);
    instr_valid = 1'b1; opcode = op;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    n = 1;
    while (!instr_ready && n < 12) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_cycles));
  endtask

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] BAD = 4'b1110;

  initial begin
    rst = 1'b1; instr_valid = 1'b0; opcode = 4'b0000;
    zero_flag = 1'b0; dmem_ack = 1'b0;

    //   rst iv  op     zf ack  rdy aop    src rw m2r req we irw pcw pcs  ill
    add(1, 0, 4'h0,  0, 0, o(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0)); // reset
    add(0, 0, 4'h0,  0, 0, o(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0)); // IDLE
    // ADD; opcode garbage after accept must be ignored
    add(0, 1, ADD,   0, 0, o(1, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2'd0, 0)); // FETCH
    add(0, 1, 4'hF,  0, 0, o(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0)); // DEC
    add(0, 1, 4'hF,  1, 1, o(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0)); // EXEC
    add(0, 1, 4'hF,  0, 0, o(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'd0, 0)); // WB
    // LD, ack in EXEC ignored, then 2 wait cycles + ack: 3 MEM cycles
    add(0, 1, 4'h0,  0, 0, o(1, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2'd0, 0));
    add(0, 0, 4'h0,  0, 1, o(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    add(0, 0, 4'h0,  0, 1, o(0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0)); // EXEC
    add(0, 0, 4'h0,  0, 0, o(0, 2'b10, 1, 0, 0, 1, 0, 0, 0, 2'd0, 0)); // MEM
    add(0, 0, 4'h0,  0, 0, o(0, 2'b10, 1, 0, 0, 1, 0, 0, 0, 2'd0, 0)); // MEM
    add(0, 0, 4'h0,  0, 1, o(0, 2'b10, 1, 0, 0, 1, 0, 0, 0, 2'd0, 0)); // MEM
    add(0, 0, 4'h0,  0, 0, o(0, 2'b10, 1, 1, 1, 0, 0, 0, 0, 2'd0, 0)); // WB
    // ST, ack in first MEM cycle
    add(0, 1, 4'h1,  0, 0, o(1, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2'd0, 0));
    add(0, 0, 4'h1,  0, 0, o(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    add(0, 0, 4'h1,  0, 0, o(0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    add(0, 0, 4'h1,  0, 1, o(0, 2'b10, 1, 0, 0, 1, 1, 0, 0, 2'd0, 0));
    // BEQ taken / not taken
    add(0, 1, 4'hB,  0, 0, o(1, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2'd0, 0));
    add(0, 0, 4'hB,  0, 0, o(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    add(0, 0, 4'hB,  1, 0, o(0, 2'b01, 0, 0, 0, 0, 0, 0, 1, 2'd1, 0));
    add(0, 1, 4'hB,  0, 0, o(1, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2'd0, 0));
    add(0, 0, 4'hB,  0, 0, o(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    add(0, 0, 4'hB,  0, 0, o(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0));
    // BNE not taken / taken
    add(0, 1, 4'hC,  0, 0, o(1, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2'd0, 0));
    add(0, 0, 4'hC,  0, 0, o(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    add(0, 0, 4'hC,  1, 0, o(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0));
    add(0, 1, 4'hC,  0, 0, o(1, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2'd0, 0));
    add(0, 0, 4'hC,  0, 0, o(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    add(0, 0, 4'hC,  0, 0, o(0, 2'b01, 0, 0, 0, 0, 0, 0, 1, 2'd1, 0));
    // JMP: redirect in DECODE, then FETCH idles without valid
    add(0, 1, 4'hD,  0, 0, o(1, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2'd0, 0));
    add(0, 0, 4'hD,  0, 0, o(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'd2, 0));
    add(0, 0, 4'hD,  0, 0, o(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    // Illegal 1110: TRAP is sticky and never ready, even with valid held high
    add(0, 1, BAD,   0, 0, o(1, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2'd0, 0));
    add(0, 1, ADD,   0, 0, o(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    add(0, 1, ADD,   0, 1, o(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1));
    add(0, 1, ADD,   1, 1, o(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1));
    add(0, 1, ADD,   0, 0, o(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1));
    // Reset clears the trap
    add(1, 1, ADD,   0, 0, o(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));

    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; instr_valid = vecs[i].iv; opcode = vecs[i].op;
      zero_flag = vecs[i].zf; dmem_ack = vecs[i].ack;
      #1;
      check($sformatf("vec%0d", i), 32'(actual()), 32'(vecs[i].exp));
      @(posedge clk); #1;
    end

    // LD run interrupted by reset while in MEM.
    rst = 1'b0; instr_valid = 1'b0; dmem_ack = 1'b0; zero_flag = 1'b0;
    @(posedge clk); #1;                          // IDLE -> FETCH
    instr_valid = 1'b1; opcode = 4'h0;
    @(posedge clk); #1;                          // -> DECODE
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);                   // -> EXEC -> MEM
    #1;
    check("mem_req_before_rst", 32'(dmem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mem_rst_outputs", 32'(actual()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Accept-to-accept latency per class, ack held so MEM takes one cycle.
    dmem_ack = 1'b1;
    latency("jmp", 4'hD, 2);
    latency("beq", 4'hB, 3);
    latency("add", ADD,  4);
    latency("st",  4'h1, 4);
    latency("ld",  4'h0, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
